// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared types and defaults for the regfile_sync_clr register file.
//   rf_state_t : clear-sequencer state (IDLE, CLEAR)
//   RF_DATA_W  : default register width
//   RF_ADDR_W  : default address width
//   rf_depth() : number of registers for a given address width
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W = 8;
    localparam int RF_ADDR_W = 3;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq
// Clear sequencer for the register file. After reset, or on clr_req while
// idle, it walks clr_ptr from 0 to DEPTH-1 and takes over the array write
// port to zero one register per cycle.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   clr_req       : single-cycle clear request (ignored while clearing)
//   wr_en         : external write enable, used only to flag dropped writes
//   state         : current sequencer state (debug / read zeroing)
//   clr_busy      : registered, high while in CLEAR
//   wr_drop       : registered pulse, a write arrived during CLEAR
//   clr_we        : write-port mux select, sequencer owns the array port
//   clr_addr      : address being zeroed
//   clr_data      : zero data for the array write port
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    input  logic              wr_en,
    output rf_state_t         state,
    output logic              clr_busy,
    output logic              wr_drop,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic [DATA_W-1:0] clr_data
);

    localparam int DEPTH = rf_depth(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rf_state_t         state_q,    state_d;
    logic [ADDR_W-1:0] clr_ptr_q,  clr_ptr_d;
    logic              clr_busy_q, clr_busy_d;
    logic              wr_drop_q,  wr_drop_d;

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        clr_busy_d = clr_busy_q;
        wr_drop_d  = (state_q == CLEAR) && wr_en;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d    = CLEAR;
                    clr_ptr_d  = '0;
                    clr_busy_d = 1'b1;
                end
            end
            CLEAR: begin
                // The wrap back to 0 on the last write is harmless: the
                // pointer is only consumed while in CLEAR.
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d    = IDLE;
                    clr_busy_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset lands in CLEAR so the array is zeroed before first use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            clr_busy_q <= 1'b1;
            wr_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            clr_busy_q <= clr_busy_d;
            wr_drop_q  <= wr_drop_d;
        end
    end

    assign state    = state_q;
    assign clr_busy = clr_busy_q;
    assign wr_drop  = wr_drop_q;
    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = clr_ptr_q;
    assign clr_data = '0;

endmodule

// File: rtl/regfile_sync_clr.sv
// regfile_sync_clr
// Two-read / one-write register file with synchronous (1-cycle) reads and a
// built-in clear sequencer that zeroes the array after reset or on request.
// Configuration macro: REGFILE_BYPASS_EN
//   defined   : a same-address read during an IDLE write returns wr_data
//   undefined : a same-address read during a write returns the old content
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   rd_en1/2, rd_addr1/2  : read enables and addresses
//   rd_data1/2            : registered read data (held when enable is low)
//   wr_en, wr_addr, wr_data : write port (discarded while clearing)
//   clr_req               : single-cycle request to zero the array
//   clr_busy              : clear sequence in progress
//   wr_drop               : pulse, a write was discarded during a clear
module regfile_sync_clr
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en1,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic              rd_en2,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              wr_drop
);

    localparam int DEPTH = rf_depth(ADDR_W);

    rf_state_t         seq_state;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;

    regfile_clear_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .wr_en    (wr_en),
        .state    (seq_state),
        .clr_busy (clr_busy),
        .wr_drop  (wr_drop),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_data (clr_data)
    );

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_data;
    logic              in_clear;
    logic              byp1, byp2;
    logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
    logic [DATA_W-1:0] rd_data2_q, rd_data2_d;

    assign in_clear = (seq_state == CLEAR);

    // Single array write port: the sequencer owns it while clearing, so any
    // external write in that window is simply not selected.
    always_comb begin
        arr_we   = clr_we | wr_en;
        arr_addr = clr_we ? clr_addr : wr_addr;
        arr_data = clr_we ? clr_data : wr_data;
    end

    // The array itself has no reset; the clear sequence initialises it.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem_q[arr_addr] <= arr_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Per-port forwarding of the write in flight; only meaningful in IDLE.
    always_comb begin
        byp1 = !in_clear && wr_en && (wr_addr == rd_addr1);
        byp2 = !in_clear && wr_en && (wr_addr == rd_addr2);
    end
`else
    always_comb begin
        byp1 = 1'b0;
        byp2 = 1'b0;
    end
`endif

    always_comb begin
        rd_data1_d = rd_data1_q;
        rd_data2_d = rd_data2_q;
        if (rd_en1) begin
            if (in_clear)  rd_data1_d = '0;
            else if (byp1) rd_data1_d = wr_data;
            else           rd_data1_d = mem_q[rd_addr1];
        end
        if (rd_en2) begin
            if (in_clear)  rd_data2_d = '0;
            else if (byp2) rd_data2_d = wr_data;
            else           rd_data2_d = mem_q[rd_addr2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data1_q <= '0;
            rd_data2_q <= '0;
        end else begin
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
        end
    end

    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;

endmodule

// File: tb/tb_regfile_sync_clr.sv
// tb_regfile_sync_clr
// Self-checking bench for regfile_sync_clr (DATA_W=8, ADDR_W=3).
// Honours REGFILE_BYPASS_EN for the read-during-write expectations.
module tb_regfile_sync_clr;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          rd_en1, rd_en2;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          clr_req;
    logic          clr_busy;
    logic          wr_drop;

    regfile_sync_clr #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_en1   (rd_en1),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1),
        .rd_en2   (rd_en2),
        .rd_addr2 (rd_addr2),
        .rd_data2 (rd_data2),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .wr_drop  (wr_drop)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          re1;
        logic [AW-1:0] ra1;
        logic          re2;
        logic [AW-1:0] ra2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q1[$];
    logic [DW-1:0] exp_q2[$];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] prev1, prev2;
    vec_t          vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    // One IDLE cycle: drive, queue expectations, clock, pop and compare.
    task automatic apply(input vec_t v, input string name);
        logic [DW-1:0] x1, x2;
        wr_en    = v.we;
        wr_addr  = v.wa;
        wr_data  = v.wd;
        rd_en1   = v.re1;
        rd_addr1 = v.ra1;
        rd_en2   = v.re2;
        rd_addr2 = v.ra2;
        exp_q1.push_back(v.e1);
        exp_q2.push_back(v.e2);
        tick();
        x1 = exp_q1.pop_front();
        x2 = exp_q2.pop_front();
        chk({name, "_rd1"}, rd_data1, x1);
        chk({name, "_rd2"}, rd_data2, x2);
        chk({name, "_busy"}, clr_busy, 0);
        chk({name, "_drop"}, wr_drop, 0);
        if (v.we) model[v.wa] = v.wd;
        prev1 = v.e1;
        prev2 = v.e2;
        wr_en  = 1'b0;
        rd_en1 = 1'b0;
        rd_en2 = 1'b0;
    endtask

    function automatic vec_t mk(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic re1, input logic [AW-1:0] ra1,
                                input logic re2, input logic [AW-1:0] ra2);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.re1 = re1; v.ra1 = ra1; v.re2 = re2; v.ra2 = ra2;
        v.e1 = !re1 ? prev1 : ((BYP && we && wa == ra1) ? wd : model[ra1]);
        v.e2 = !re2 ? prev2 : ((BYP && we && wa == ra2) ? wd : model[ra2]);
        return v;
    endfunction

    // ---------------- test ----------------
    int n;

    initial begin
        vt[0] = '{1'b1, 3'd5, 8'hA5, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00};
        vt[1] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b1, 3'd5, 8'hA5, 8'hA5};
        vt[2] = '{1'b1, 3'd2, 8'h11, 1'b1, 3'd3, 1'b0, 3'd0, 8'h00, 8'hA5};
        vt[3] = '{1'b1, 3'd2, 8'h3C, 1'b1, 3'd2, 1'b1, 3'd2,
                  BYP ? 8'h3C : 8'h11, BYP ? 8'h3C : 8'h11};
        vt[4] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd5, 8'h3C, 8'hA5};
        vt[5] = '{1'b1, 3'd0, 8'h5A, 1'b1, 3'd0, 1'b0, 3'd0, BYP ? 8'h5A : 8'h00, 8'hA5};
        vt[6] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd0, 8'h5A, 8'h5A};
        vt[7] = '{1'b1, 3'd7, 8'h99, 1'b1, 3'd5, 1'b1, 3'd7, 8'hA5, BYP ? 8'h99 : 8'h00};
        vt[8] = '{1'b1, 3'd3, 8'h42, 1'b0, 3'd0, 1'b0, 3'd0, 8'hA5, BYP ? 8'h99 : 8'h00};
        vt[9] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd7, 8'h42, 8'h99};

        reset    = 1'b1;
        rd_en1   = 1'b1;
        rd_addr1 = 3'd3;
        rd_en2   = 1'b0;
        rd_addr2 = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        clr_req  = 1'b0;

        // Reset release: clear runs 8 cycles, reads return 0 throughout.
        repeat (3) tick();
        chk("reset_busy", clr_busy, 1);
        chk("reset_drop", wr_drop, 0);
        chk("reset_rd1", rd_data1, 0);
        chk("reset_rd2", rd_data2, 0);
        reset = 1'b0;
        n = 0;
        while (clr_busy === 1'b1 && n < 20) begin
            n++;
            chk("init_clear_rd1", rd_data1, 0);
            tick();
        end
        chk("init_clear_len", n, 8);
        tick();
        chk("init_idle_rd1", rd_data1, 0);
        rd_en1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        prev1 = '0;
        prev2 = '0;

        // Directed vector table.
        for (int i = 0; i < 10; i++) apply(vt[i], $sformatf("vec%0d", i));

        // Randomised IDLE traffic against the model.
        for (int i = 0; i < 40; i++) begin
            apply(mk(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                     DW'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                     1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1))),
                  "rand");
        end

        // Requested clear over an all-0xFF array, with a dropped write and
        // an ignored re-request inside the sequence.
        for (int i = 0; i < DEPTH; i++) apply(mk(1'b1, AW'(i), 8'hFF, 1'b0, '0, 1'b0, '0), "fill");
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (clr_busy === 1'b1 && n < 20) begin
            n++;
            if (n == 2) begin
                wr_en    = 1'b1;
                wr_addr  = 3'd1;
                wr_data  = 8'h77;
                rd_en1   = 1'b1;
                rd_addr1 = 3'd1;
                clr_req  = 1'b1;
            end else begin
                wr_en   = 1'b0;
                rd_en1  = 1'b0;
                clr_req = 1'b0;
            end
            tick();
            if (n == 2) begin
                chk("clear_drop_pulse", wr_drop, 1);
                chk("clear_rd_zero", rd_data1, 0);
            end
            if (n == 3) chk("clear_drop_fall", wr_drop, 0);
        end
        wr_en   = 1'b0;
        rd_en1  = 1'b0;
        clr_req = 1'b0;
        chk("req_clear_len", n, 8);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        prev1 = '0;
        for (int i = 0; i < DEPTH; i++)
            apply('{1'b0, '0, '0, 1'b1, AW'(i), 1'b1, AW'(DEPTH - 1 - i), 8'h00, 8'h00}, "post_clear");

        // Reset mid-clear restarts the sequence; a re-request does not extend it.
        apply(mk(1'b1, 3'd6, 8'h66, 1'b0, '0, 1'b0, '0), "pre_w6");
        apply('{1'b0, '0, '0, 1'b0, '0, 1'b1, 3'd6, prev1, 8'h66}, "pre_r6");
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (clr_busy === 1'b1 && n < 4) begin
            n++;
            tick();
        end
        chk("mid_reach4", n, 4);
        reset = 1'b1;
        #1;
        chk("mid_reset_busy", clr_busy, 1);
        chk("mid_reset_drop", wr_drop, 0);
        chk("mid_reset_rd2", rd_data2, 0);
        tick();
        reset = 1'b0;
        n = 0;
        while (clr_busy === 1'b1 && n < 20) begin
            n++;
            clr_req = (n == 3);
            tick();
        end
        clr_req = 1'b0;
        chk("restart_clear_len", n, 8);
        prev1 = '0;
        prev2 = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        apply('{1'b0, '0, '0, 1'b1, 3'd6, 1'b1, 3'd4, 8'h00, 8'h00}, "restart_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sync_clr.md
# regfile_sync_clr

Parametrised two-read/one-write register file for the 8-bit RISC datapath, replacing the fixed 8×8 array with configurable width and depth. Reads are synchronous with a one-cycle latency. A built-in clear sequencer zeroes the array after reset or on request, so software never sees uninitialised registers. It sits between decode (read addresses) and writeback (write port).

## Interface
- `DATA_W`, 8, register width in bits
- `ADDR_W`, 3, address width; depth `DEPTH = 2**ADDR_W`; legal range 1..8

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `rd_en1`, `rd_en2`  in  1  read enable, port 1 / port 2
- `rd_addr1`, `rd_addr2`  in  ADDR_W  read address
- `rd_data1`, `rd_data2`  out  DATA_W  registered read data
- `wr_en`  in  1  write enable
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write data
- `clr_req`  in  1  single-cycle request to zero the whole array
- `clr_busy`  out  1  clear sequence in progress
- `wr_drop`  out  1  one-cycle pulse: a write was discarded during a clear

## Operation
- FSM states: IDLE and CLEAR. A `clr_ptr` counter of ADDR_W bits is active in CLEAR.
- **Reset:** `reset` high forces CLEAR with `clr_ptr=0`, `rd_data1/2=0`, `clr_busy=1`, `wr_drop=0`. The array itself is not reset.
- **CLEAR:**
  - Each cycle writes 0 to `reg[clr_ptr]` and increments `clr_ptr`.
  - The cycle that writes `DEPTH-1` transitions to IDLE.
  - CLEAR lasts exactly DEPTH cycles.
- **IDLE + `clr_req`:** enters CLEAR next edge with `clr_ptr=0`.
- **`clr_req` while in CLEAR:** ignored. The sequence is not restarted.
- **Reset asserted mid-clear:** the sequence restarts from 0 after deassertion.
- **Write in IDLE:** with `wr_en=1`, `reg[wr_addr] <= wr_data` on the edge. Any address is writable, including 0.
- **Write in CLEAR:** with `wr_en=1` the write is discarded and `wr_drop` is 1 for the following cycle. Back-to-back dropped writes hold `wr_drop` high.
- **Read in IDLE:** `rd_enN=1` loads `rd_dataN <= reg[rd_addrN]`.
- **Read in CLEAR:** `rd_enN=1` loads `rd_dataN <= 0`.
- **Read disabled:** `rd_enN=0` holds the previous `rd_dataN`.
- **Same address on both ports:** legal; both ports return identical data.
- **Read-during-write** (IDLE, `rd_addrN==wr_addr`, both enables high): behaviour is set by the configuration macro.

## Timing
- Read latency is 1 cycle: the address is sampled at edge k and data is valid after edge k.
- Write is visible to a read issued on the next edge; same-edge visibility depends on the macro.
- `clr_busy` timing:
  - Registered.
  - Rises on the edge after `clr_req` is accepted.
  - Falls on the edge after the `DEPTH-1` write.
- Clear after reset deassert: first IDLE cycle is the (DEPTH+1)th edge.
- `wr_drop` is registered with 1-cycle latency.

## Configuration
- `REGFILE_BYPASS_EN`, defined: a read-during-write to the same address returns `wr_data` (new data). Forwarding is per port and only active in IDLE.
- `REGFILE_BYPASS_EN`, undefined: a read-during-write returns the old array content. Decode must stall one cycle for dependent reads.

## Structure
- Package `regfile_pkg`:
  - State enum `rf_state_t` {IDLE, CLEAR}.
  - Default-width localparams.
  - Function `rf_depth(ADDR_W)`.
- Sub-module `regfile_clear_seq`:
  - Owns the FSM, `clr_ptr`, `clr_busy` and `wr_drop`.
  - Outputs the internal write-port mux select, address and zero data.
- The top level holds the array, the read registers and the bypass muxes.

## Test plan
- **Reset release:** release `reset` and hold `rd_en1=1`, `rd_addr1=3` → `clr_busy=1` for 8 cycles, `rd_data1=0` throughout, and after IDLE `rd_data1=0x00`.
- **Write then read:** in IDLE write 0xA5 to reg 5, then read reg 5 on both ports the next cycle → `rd_data1 = rd_data2 = 0xA5` one cycle later.
- **Same-cycle read/write:** write 0x3C to reg 2 while reading reg 2 (old value 0x11) → 0x3C with `REGFILE_BYPASS_EN`, 0x11 without.
- **Request clear:** fill all 8 regs with 0xFF, then pulse `clr_req` → `clr_busy` high exactly 8 cycles, and all reads afterwards return 0x00.
- **Writes during clear:** write 0x77 to reg 1 during CLEAR → `wr_drop=1` next cycle, and reg 1 reads 0x00 after the clear.
- **Reset and re-request mid-clear:** assert `reset` at clear cycle 4 → the sequence restarts with `clr_ptr=0`, `clr_busy` lasts 8 cycles after deassert, and a `clr_req` during CLEAR does not extend it.
